// File: rtl/core_seq.sv
// Minimal instruction sequencer: fetches words, executes ADDI, writes back and retires.
// Anything else, or a fetch that never completes, parks the core in HALT until reset.
module core_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic [31:0] retire_inst,
    output logic        halt,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state, state_nx;
    logic [31:0] pc, inst, result, retired_q;
    logic [7:0]  wcnt;
    logic [8:0]  wcnt_nx;
    logic [1:0]  cause;
    logic        is_addi, fetch_to;

    assign is_addi  = (inst[6:2] == 5'b00100) && (inst[14:12] == 3'b000);
    assign wcnt_nx  = {1'b0, wcnt} + 9'd1;
    assign fetch_to = (wcnt_nx == TIMEOUT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        imem_req     = 1'b0;
        rf_raddr     = 5'd0;
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_wdata     = 32'd0;
        retire_valid = 1'b0;
        retire_pc    = 32'd0;
        retire_inst  = 32'd0;
        case (state)
            IDLE: if (run) state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                // ack beats a timeout landing on the same cycle
                if (imem_ack)      state_nx = EXEC;
                else if (fetch_to) state_nx = HALT;
            end
            EXEC: begin
                rf_raddr = inst[19:15];
                state_nx = is_addi ? WB : HALT;
            end
            WB: begin
                rf_we        = (inst[11:7] != 5'd0);
                rf_waddr     = inst[11:7];
                rf_wdata     = result;
                retire_valid = 1'b1;
                retire_pc    = pc;
                retire_inst  = inst;
                state_nx     = run ? FETCH : IDLE;
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            inst      <= 32'd0;
            result    <= 32'd0;
            wcnt      <= 8'd0;
            retired_q <= 32'd0;
            cause     <= 2'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        inst <= imem_rdata;
                        wcnt <= 8'd0;
                    end else begin
                        wcnt <= wcnt_nx[7:0];
                        if (fetch_to) cause <= 2'd2;
                    end
                end
                EXEC: begin
                    if (is_addi) result <= rf_rdata + {{20{inst[31]}}, inst[31:20]};
                    else         cause  <= 2'd1;
                end
                WB: begin
                    pc        <= pc + 32'd4;
                    retired_q <= retired_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc;
    assign halt       = (state == HALT);
    assign halt_cause = cause;
    assign retired    = retired_q;

endmodule
